// File: rtl/portin_deser.sv
`default_nettype none
// ============================================================================
//  Module      : portin_deser
//  Description : Router serial input port. Deserialises one framed, LSB-first
//                bit stream into address-tagged payload words, buffers them in
//                a small show-ahead FIFO and presents them on a valid/ready
//                interface with SOP/EOP, partial-word length, and runt /
//                overflow reporting.
//  Revision    : 1.0  initial release
// ============================================================================
module portin_deser #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          frame_n,
  input  logic                          valid_n,
  input  logic                          di,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [ADDR_W-1:0]             out_addr,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [$clog2(DATA_W+1)-1:0]   out_nbits,
  output logic                          out_err,
  output logic                          ovf,
  output logic                          runt,
  output logic                          busy
);

  localparam int NB_W  = $clog2(DATA_W + 1);
  localparam int BC_W  = $clog2(DATA_W);
  localparam int AC_W  = $clog2(ADDR_W + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_ADDR    = 2'd2,
    ST_PAYLOAD = 2'd3
  } state_t;

  typedef struct packed {
    logic              err;
    logic              eop;
    logic              sop;
    logic [NB_W-1:0]   nbits;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // ---------------------------------------------------------------- state
  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [AC_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic [BC_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic              wemit_q,    wemit_d;    // a word of this packet already completed

  // Completed word waiting to be written. A full word is held here until the
  // stream shows whether more payload follows, so that a packet ending on a
  // word boundary can still mark that word EOP. Flush words (rel) leave on
  // the very next edge.
  logic              pw_valid_q, pw_valid_d;
  logic [DATA_W-1:0] pw_data_q,  pw_data_d;
  logic [NB_W-1:0]   pw_nbits_q, pw_nbits_d;
  logic              pw_sop_q,   pw_sop_d;
  logic              pw_eop_q,   pw_eop_d;
  logic              pw_rel_q,   pw_rel_d;

  logic              drop_q,     drop_d;     // current packet lost a word
  logic              tok_pend_q, tok_pend_d; // error token waiting for a slot
  logic [ADDR_W-1:0] tok_addr_q, tok_addr_d;

  entry_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;

  logic              out_valid_q, out_valid_d;
  entry_t            out_ent_q,   out_ent_d;
  logic              ovf_q,       ovf_d;
  logic              runt_q,      runt_d;
  logic              busy_q,      busy_d;

  // ---------------------------------------------------------------- wires
  logic              in_pay;
  logic              pw_go;
  logic              pw_go_eop;
  logic [DATA_W-1:0] shift_nx;
  logic              pop;
  logic              full;
  logic              can_wr;
  logic              wr_en;
  entry_t            wr_entry;
  entry_t            tok_entry;
  entry_t            word_entry;
  logic              w_drop;
  logic [CNT_W-1:0]  vis_cnt;
  logic [PTR_W-1:0]  head_ptr;

  // Release of the held word: flushes go unconditionally; a held full word
  // goes when the next payload bit arrives or the packet ends without one.
  always_comb begin
    in_pay    = (state_q == ST_PAYLOAD);
    pw_go     = pw_valid_q && (pw_rel_q || (in_pay && (!valid_n || frame_n)));
    pw_go_eop = pw_eop_q || (in_pay && valid_n && frame_n);
    shift_nx  = shift_q | (DATA_W'(di) << bit_cnt_q);
  end

  // Framing FSM and deserialiser next-state
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    addr_cnt_d = addr_cnt_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    wemit_d    = wemit_q;
    pw_valid_d = pw_valid_q && !pw_go;
    pw_data_d  = pw_data_q;
    pw_nbits_d = pw_nbits_q;
    pw_sop_d   = pw_sop_q;
    pw_eop_d   = pw_eop_q;
    pw_rel_d   = pw_rel_q;
    runt_d     = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (frame_n) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (!frame_n) begin
          addr_d     = (addr_q >> 1) | (ADDR_W'(di) << (ADDR_W - 1));
          addr_cnt_d = AC_W'(1);
          shift_d    = '0;
          bit_cnt_d  = '0;
          wemit_d    = 1'b0;
          state_d    = (ADDR_W == 1) ? ST_PAYLOAD : ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (frame_n) begin
          runt_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          addr_d     = (addr_q >> 1) | (ADDR_W'(di) << (ADDR_W - 1));
          addr_cnt_d = addr_cnt_q + AC_W'(1);
          if (addr_cnt_q == AC_W'(ADDR_W - 1)) begin
            state_d = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (!valid_n) begin
          if (bit_cnt_q == BC_W'(DATA_W - 1) || frame_n) begin
            pw_valid_d = 1'b1;
            pw_data_d  = shift_nx;
            pw_nbits_d = NB_W'(bit_cnt_q) + NB_W'(1);
            pw_sop_d   = !wemit_q;
            pw_eop_d   = frame_n;
            pw_rel_d   = frame_n;
            shift_d    = '0;
            bit_cnt_d  = '0;
            wemit_d    = 1'b1;
          end else begin
            shift_d   = shift_nx;
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
          if (frame_n) begin
            state_d = ST_IDLE;
          end
        end else if (frame_n) begin
          state_d = ST_IDLE;
          if (bit_cnt_q != '0) begin
            // Partial word becomes the EOP flush.
            pw_valid_d = 1'b1;
            pw_data_d  = shift_q;
            pw_nbits_d = NB_W'(bit_cnt_q);
            pw_sop_d   = !wemit_q;
            pw_eop_d   = 1'b1;
            pw_rel_d   = 1'b1;
            shift_d    = '0;
            bit_cnt_d  = '0;
          end else if (!wemit_q) begin
            runt_d = 1'b1;
          end
          // else: empty flush, the held word leaves this cycle tagged EOP.
        end
      end

      default: state_d = ST_SYNC;
    endcase
  end

  // FIFO write arbitration: pending error token first, then the held word.
  always_comb begin
    pop    = out_valid_q && out_ready;
    full   = (count_q == CNT_W'(FIFO_DEPTH));
    can_wr = !full || pop;

    tok_entry       = '0;
    tok_entry.eop   = 1'b1;
    tok_entry.err   = 1'b1;
    tok_entry.addr  = tok_addr_q;

    word_entry       = '0;
    word_entry.data  = pw_data_q;
    word_entry.addr  = addr_q;
    word_entry.sop   = pw_sop_q;
    word_entry.eop   = pw_go_eop;
    word_entry.nbits = pw_nbits_q;

    wr_en      = 1'b0;
    wr_entry   = '0;
    w_drop     = drop_q;
    ovf_d      = 1'b0;
    drop_d     = drop_q;
    tok_pend_d = tok_pend_q;
    tok_addr_d = tok_addr_q;

    if (tok_pend_q && can_wr) begin
      wr_en      = 1'b1;
      wr_entry   = tok_entry;
      tok_pend_d = 1'b0;
    end

    if (pw_go) begin
      if (!drop_q) begin
        if (tok_pend_q && can_wr) begin
          w_drop = 1'b1;            // lost to the token, slot was free
        end else if (!can_wr) begin
          w_drop = 1'b1;
          ovf_d  = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wr_entry = word_entry;
        end
      end
      if (pw_go_eop) begin
        // A truncated packet owes a token. Only one can be outstanding; if
        // another is still waiting the newest packet's address is reported.
        drop_d = 1'b0;
        if (w_drop) begin
          tok_pend_d = 1'b1;
          tok_addr_d = addr_q;
        end
      end else begin
        drop_d = w_drop;
      end
    end
  end

  // FIFO pointers and the registered show-ahead head. The head reflects only
  // entries stored before this edge, giving two edges from last bit to valid.
  always_comb begin
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    vis_cnt  = count_q - CNT_W'(pop);
    head_ptr = rd_ptr_q + PTR_W'(pop);
    out_valid_d = (vis_cnt != '0);
    out_ent_d   = out_valid_d ? mem_q[head_ptr] : '0;
    busy_d      = (state_d == ST_ADDR) || (state_d == ST_PAYLOAD);
  end

  // All control and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      addr_q      <= '0;
      addr_cnt_q  <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      wemit_q     <= 1'b0;
      pw_valid_q  <= 1'b0;
      pw_data_q   <= '0;
      pw_nbits_q  <= '0;
      pw_sop_q    <= 1'b0;
      pw_eop_q    <= 1'b0;
      pw_rel_q    <= 1'b0;
      drop_q      <= 1'b0;
      tok_pend_q  <= 1'b0;
      tok_addr_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_ent_q   <= '0;
      ovf_q       <= 1'b0;
      runt_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      addr_cnt_q  <= addr_cnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      wemit_q     <= wemit_d;
      pw_valid_q  <= pw_valid_d;
      pw_data_q   <= pw_data_d;
      pw_nbits_q  <= pw_nbits_d;
      pw_sop_q    <= pw_sop_d;
      pw_eop_q    <= pw_eop_d;
      pw_rel_q    <= pw_rel_d;
      drop_q      <= drop_d;
      tok_pend_q  <= tok_pend_d;
      tok_addr_q  <= tok_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_ent_q   <= out_ent_d;
      ovf_q       <= ovf_d;
      runt_q      <= runt_d;
      busy_q      <= busy_d;
    end
  end

  // Storage array; stale contents are never visible because the head is masked
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_ent_q.data;
  assign out_addr  = out_ent_q.addr;
  assign out_sop   = out_ent_q.sop;
  assign out_eop   = out_ent_q.eop;
  assign out_nbits = out_ent_q.nbits;
  assign out_err   = out_ent_q.err;
  assign ovf       = ovf_q;
  assign runt      = runt_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
